// File: rtl/tcb_lite_lib_memory.sv
// rtl/tcb_lite_lib_memory.sv - TCB-Lite subordinate memory with fixed response delay
//
// Synchronous RAM that terminates one TCB-Lite manager port. Writes are byte
// masked, reads return a full word, and every handshaken request produces
// exactly one response DLY cycles later. Accesses beyond SIZ words answer
// with err and never touch the array.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (memory contents are retained)
//   vld  - request valid            rdy - request ready (low only in reset)
//   wen  - 1 write / 0 read         adr - byte address
//   byt  - write byte enables       wdt - write data
//   rdt  - read data in response cycle, 0 otherwise
//   err  - out-of-range flag in response cycle, 0 otherwise
module tcb_lite_lib_memory #(
    parameter int unsigned ADR  = 32,
    parameter int unsigned DAT  = 32,
    parameter int unsigned SIZ  = 1024,
    parameter int unsigned DLY  = 1,
    parameter string       INIT = ""
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    output logic             rdy,
    input  logic             wen,
    input  logic [ADR-1:0]   adr,
    input  logic [DAT/8-1:0] byt,
    input  logic [DAT-1:0]   wdt,
    output logic [DAT-1:0]   rdt,
    output logic             err
);

    localparam int unsigned BYT  = DAT / 8;
    localparam int unsigned OFF  = $clog2(BYT);
    localparam int unsigned IW   = ADR - OFF;
    localparam int unsigned AW   = (SIZ > 1) ? $clog2(SIZ) : 1;
    localparam int unsigned LAST = DLY - 1;
    localparam logic [IW:0] SIZ_W = (IW + 1)'(SIZ);

    logic [IW-1:0]  idx;
    logic [AW-1:0]  widx;
    logic           in_range;
    logic           trn;

    // Response pipeline: stage 0 is loaded on the handshake edge, stage LAST
    // drives the outputs. Data travels separately from the control bits so
    // that the array read register stays free of reset.
    logic [DLY-1:0] vld_q;
    logic [DLY-1:0] rd_q;
    logic [DLY-1:0] err_q;
    logic [DAT-1:0] dat_q [DLY];

    logic           s0_vld_d;
    logic           s0_rd_d;
    logic           s0_err_d;

    logic [DAT-1:0] mem_q [SIZ];

    // Byte-offset address bits carry no meaning for word accesses.
    logic unused_adr;
    assign unused_adr = ^adr;

    logic unused_init;
    assign unused_init = (INIT != "");

    assign rdy      = ~rst;
    assign trn      = vld & rdy;
    assign idx      = adr[ADR-1:OFF];
    // Compare on the full index so aliasing above SIZ is caught even when
    // SIZ is not a power of two.
    assign in_range = ({1'b0, idx} < SIZ_W);
    assign widx     = idx[AW-1:0];

    always_comb begin
        s0_vld_d = trn;
        s0_rd_d  = trn & ~wen & in_range;
        s0_err_d = trn & ~in_range;
    end

    // Array and data path: no reset so the RAM infers cleanly and contents
    // survive rst. The read register samples the pre-write word.
    always_ff @(posedge clk) begin
        if (trn & in_range) begin
            if (wen) begin
                for (int b = 0; b < BYT; b++) begin
                    if (byt[b]) begin
                        mem_q[widx][8*b +: 8] <= wdt[8*b +: 8];
                    end
                end
            end else begin
                dat_q[0] <= mem_q[widx];
            end
        end
        for (int i = 1; i < DLY; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    // Control pipeline: reset drops every in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            rd_q  <= '0;
            err_q <= '0;
        end else begin
            vld_q[0] <= s0_vld_d;
            rd_q[0]  <= s0_rd_d;
            err_q[0] <= s0_err_d;
            for (int i = 1; i < DLY; i++) begin
                vld_q[i] <= vld_q[i-1];
                rd_q[i]  <= rd_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    // Outputs are gated by rst as well, so a response due in a reset cycle
    // is suppressed rather than leaking out before the clear edge.
    assign rdt = (~rst & vld_q[LAST] & rd_q[LAST]) ? dat_q[LAST] : '0;
    assign err = ~rst & vld_q[LAST] & err_q[LAST];

    always_ff @(posedge clk) begin
        assert (DLY >= 1 && DLY <= 4)
            else $error("DLY out of range 1..4");
        assert (DAT >= 8 && (DAT % 8) == 0 && (BYT & (BYT - 1)) == 0)
            else $error("DAT must be 8*2^n");
        if (!rst) begin
            assert (!$isunknown({vld, wen, adr}))
                else $error("vld/wen/adr unknown outside reset");
        end
    end

endmodule

// File: tb/tb_tcb_lite_lib_memory.sv
// tb/tb_tcb_lite_lib_memory.sv - bench for tcb_lite_lib_memory at DLY=1 and DLY=3
module tb_tcb_lite_lib_memory;

    logic        clk = 1'b0;
    logic        rst, vld, wen;
    logic [31:0] adr, wdt;
    logic [3:0]  byt;

    logic        rdy1, err1, rdy3, err3;
    logic [31:0] rdt1, rdt3;

    always #5 clk = ~clk;

    tcb_lite_lib_memory #(.ADR(32), .DAT(32), .SIZ(1024), .DLY(1), .INIT("")) u_d1 (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy1), .wen(wen), .adr(adr),
        .byt(byt), .wdt(wdt), .rdt(rdt1), .err(err1)
    );

    tcb_lite_lib_memory #(.ADR(32), .DAT(32), .SIZ(1024), .DLY(3), .INIT("")) u_d3 (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy3), .wen(wen), .adr(adr),
        .byt(byt), .wdt(wdt), .rdt(rdt3), .err(err3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word array plus a per-cycle history of what was
    // handshaken and what its response must carry.
    localparam int HN = 2048;
    logic [31:0] mem_m [1024];
    bit          h_trn [HN];
    bit          h_rst [HN];
    bit          h_err [HN];
    logic [31:0] h_rdt [HN];
    int          cyc = 0;
    int unsigned m_idx;

    // Response seen in cycle c from a pipe of depth d: the request from
    // cycle c-d, unless any reset cycle lies in (c-d, c].
    function automatic void exp_at(input int c, input int d, output bit e, output logic [31:0] r);
        e = 1'b0;
        r = 32'h0;
        if (c - d < 0) return;
        if (!h_trn[c-d]) return;
        for (int k = c - d + 1; k <= c; k++) begin
            if (h_rst[k]) return;
        end
        e = h_err[c-d];
        r = h_rdt[c-d];
    endfunction

    always @(negedge clk) begin
        bit          e;
        logic [31:0] r;
        if (cyc < HN) begin
            h_rst[cyc] = rst;
            h_trn[cyc] = !rst && vld;
            h_err[cyc] = 1'b0;
            h_rdt[cyc] = 32'h0;
            if (h_trn[cyc]) begin
                m_idx = adr >> 2;
                if (m_idx >= 1024) begin
                    h_err[cyc] = 1'b1;
                end else if (wen) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byt[b]) mem_m[m_idx][8*b +: 8] = wdt[8*b +: 8];
                    end
                end else begin
                    h_rdt[cyc] = mem_m[m_idx];
                end
            end
            chk("rdy_d1", {31'b0, rdy1}, {31'b0, !rst});
            chk("rdy_d3", {31'b0, rdy3}, {31'b0, !rst});
            exp_at(cyc, 1, e, r);
            chk("err_d1", {31'b0, err1}, {31'b0, e});
            chk("rdt_d1", rdt1, r);
            exp_at(cyc, 3, e, r);
            chk("err_d3", {31'b0, err3}, {31'b0, e});
            chk("rdt_d3", rdt3, r);
            cyc++;
        end
    end

    // All driving happens at posedge+1; each op leaves vld low afterwards.
    task automatic op(input bit w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        vld = 1'b1; wen = w; adr = a; byt = be; wdt = d;
        @(posedge clk); #1;
        vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk1(input string name, input logic [31:0] exp_rdt, input bit exp_err);
        @(negedge clk);
        chk({name, "_rdt"}, rdt1, exp_rdt);
        chk({name, "_err"}, {31'b0, err1}, {31'b0, exp_err});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pv;
        int          sel;
        int unsigned ri;

        rst = 1'b1; vld = 1'b0; wen = 1'b0; adr = '0; byt = '0; wdt = '0;
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_rdy", {31'b0, rdy1}, 32'h0);
            chk("reset_rdt", rdt3, 32'h0);
            chk("reset_err", {31'b0, err3}, 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_reset", {31'b0, rdy1}, 32'h1);
        @(posedge clk); #1;

        // Preload idx 0..15 and 1020..1023 through the bus.
        for (int i = 0; i < 20; i++) begin
            ri = (i < 16) ? i : 1004 + i;
            if (ri < 8)          pv = ri;
            else if (ri == 8)    pv = 32'h11223344;
            else if (ri == 1023) pv = 32'hCAFEF00D;
            else                 pv = $urandom;
            op(1'b1, ri * 4, 4'hF, pv);
        end
        idle(3);

        // Streaming reads on the DLY=3 instance.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    vld = 1'b1; wen = 1'b0; adr = i * 4; byt = '0;
                    @(posedge clk); #1;
                end
                vld = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("stream_early_err", {31'b0, err3}, 32'h0);
                chk("stream_early_rdt", rdt3, 32'h0);
                @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    chk("stream_rdt", rdt3, i);
                end
            end
        join
        @(posedge clk); #1;

        op(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        op(1'b0, 32'h10, 4'h0, 32'h0);
        chk1("full_rw", 32'hDEADBEEF, 1'b0);

        op(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
        op(1'b0, 32'h20, 4'h0, 32'h0);
        chk1("byte_mask", 32'h11BB33DD, 1'b0);
        op(1'b0, 32'h23, 4'h0, 32'h0);
        chk1("low_bits", 32'h11BB33DD, 1'b0);

        op(1'b1, 32'h1000, 4'hF, 32'h12345678);
        chk1("oor_write", 32'h0, 1'b1);
        op(1'b0, 32'h1000, 4'h0, 32'h0);
        chk1("oor_read", 32'h0, 1'b1);
        op(1'b0, 32'hFFC, 4'h0, 32'h0);
        chk1("last_word", 32'hCAFEF00D, 1'b0);

        // Reset while two DLY=3 responses are in flight.
        idle(3);
        vld = 1'b1; wen = 1'b0; adr = 32'hFFC;
        @(posedge clk); #1;
        adr = 32'h1000;
        @(posedge clk); #1;
        vld = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_t3_rdt", rdt3, 32'h0);
        chk("flush_t3_err", {31'b0, err3}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_t4_rdt", rdt3, 32'h0);
        chk("flush_t4_err", {31'b0, err3}, 32'h0);
        @(posedge clk); #1;
        op(1'b0, 32'hFFC, 4'h0, 32'h0);
        chk1("retained", 32'hCAFEF00D, 1'b0);

        // Randomized traffic restricted to preloaded words or out-of-range.
        repeat (400) begin
            rst = ($urandom_range(59) == 0);
            vld = ($urandom_range(3) != 0);
            wen = $urandom_range(1);
            sel = $urandom_range(9);
            if (sel < 7)       ri = $urandom_range(15);
            else if (sel == 7) ri = 1020 + $urandom_range(3);
            else if (sel == 8) ri = 1024 + $urandom_range(63);
            else               ri = $urandom | 32'h2000_0000;
            adr = (ri << 2) | $urandom_range(3);
            byt = $urandom;
            wdt = $urandom;
            @(posedge clk); #1;
        end
        rst = 1'b0; vld = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
